// File: rtl/api_pkg.sv
// Frame geometry and shared types for the API serial link.
// Used by both the controller side and the miner-side responder so
// the two ends agree on word width, frame length and the idle pattern.
package api_pkg;

  localparam int WORD_W   = 32;
  localparam int WORK_LEN = 23;

  localparam logic [WORD_W-1:0] IDLE_WORD = 32'hFFFF_FFFF;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } frame_state_t;

endpackage

// File: rtl/api_miner_spi_if.sv
// Bundle of the miner responder's link, work and nonce signals.
// slave: the miner responder; master: controller plus hash core side.
interface api_miner_spi_if #(
  parameter int NONCE_DEPTH = 8
);
  localparam int CNT_W = $clog2(NONCE_DEPTH) + 1;

  logic             load;
  logic             sck;
  logic             mosi;
  logic             miso;
  logic [31:0]      work_data;
  logic             work_push;
  logic             work_done;
  logic             frame_err;
  logic [31:0]      nonce_din;
  logic             nonce_push;
  logic             nonce_full;
  logic [CNT_W-1:0] nonce_cnt;
  logic             busy;

  modport slave (
    input  load, sck, mosi, nonce_din, nonce_push,
    output miso, work_data, work_push, work_done, frame_err,
           nonce_full, nonce_cnt, busy
  );

  modport master (
    output load, sck, mosi, nonce_din, nonce_push,
    input  miso, work_data, work_push, work_done, frame_err,
           nonce_full, nonce_cnt, busy
  );

endinterface

// File: rtl/api_nonce_fifo.sv
// Small synchronous nonce FIFO with first-word-fall-through output.
// A push while full only lands if a pop frees a slot in the same cycle;
// a pop while empty is ignored (the caller substitutes its idle word).
module api_nonce_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  // Storage array; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/api_miner_spi.sv
// Miner-side responder for the API serial link.
// Reassembles 32-bit work words from mosi and streams queued nonces
// (or the idle word) back on miso, MSB first, in the same transfer.
//
// state     | meaning
// ----------+--------------------------------------------------
// ST_IDLE   | no frame; sck ignored, miso held 0
// ST_ACTIVE | frame open (synced load high); shifting in/out
module api_miner_spi
  import api_pkg::*;
#(
  parameter int NONCE_DEPTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  api_miner_spi_if.slave bus
);
  localparam int CNT_W = $clog2(NONCE_DEPTH) + 1;
  localparam int BC_W  = $clog2(WORD_W);
  localparam int WC_W  = $clog2(WORK_LEN + 2);
  // word_cnt saturates one past WORK_LEN so an over-long frame stays flagged.
  localparam logic [WC_W-1:0] WL    = WC_W'(WORK_LEN);
  localparam logic [WC_W-1:0] WL_M1 = WC_W'(WORK_LEN - 1);

  logic r_load_s1, r_load_s2, r_load_h;
  logic r_sck_s1, r_sck_s2, r_sck_h;
  logic r_mosi_s1, r_mosi_s2;
  logic w_load_rise, w_load_fall, w_sck_rise, w_sck_fall;

  frame_state_t r_state, w_state_nxt;
  logic w_start, w_end, w_rise, w_fall;

  logic [BC_W-1:0]   r_bit_cnt;
  logic [WC_W-1:0]   r_word_cnt;
  logic              r_first;
  logic [WORD_W-1:0] r_rx_shift;
  logic [WORD_W-1:0] r_tx_shift;
  logic [WORD_W-1:0] r_work_data;
  logic              r_work_push;
  logic              r_work_done;
  logic              r_frame_err;

  logic              w_pop;
  logic              w_fifo_empty;
  logic              w_fifo_full;
  logic [WORD_W-1:0] w_fifo_dout;
  logic [WORD_W-1:0] w_head;
  logic [CNT_W-1:0]  w_fifo_count;

  // Two-flop synchronisers for the controller inputs, plus edge history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load_s1 <= 1'b0;
      r_load_s2 <= 1'b0;
      r_load_h  <= 1'b0;
      r_sck_s1  <= 1'b0;
      r_sck_s2  <= 1'b0;
      r_sck_h   <= 1'b0;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
    end else begin
      r_load_s1 <= bus.load;
      r_load_s2 <= r_load_s1;
      r_load_h  <= r_load_s2;
      r_sck_s1  <= bus.sck;
      r_sck_s2  <= r_sck_s1;
      r_sck_h   <= r_sck_s2;
      r_mosi_s1 <= bus.mosi;
      r_mosi_s2 <= r_mosi_s1;
    end
  end

  assign w_load_rise = r_load_s2 & ~r_load_h;
  assign w_load_fall = ~r_load_s2 & r_load_h;
  assign w_sck_rise  = r_sck_s2 & ~r_sck_h;
  assign w_sck_fall  = ~r_sck_s2 & r_sck_h;

  // Frame state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Frame open/close decisions; sck edges only count while a frame is open
  // and never in the cycle that opens or closes it.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_end       = 1'b0;
    w_rise      = 1'b0;
    w_fall      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_load_rise) begin
          w_start     = 1'b1;
          w_state_nxt = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (w_load_fall) begin
          w_end       = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_rise = w_sck_rise;
          w_fall = w_sck_fall;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A new tx word is needed at frame start and after each full word sent.
  assign w_pop  = w_start | (w_fall & (r_bit_cnt == '0) & ~r_first);
  assign w_head = w_fifo_empty ? IDLE_WORD : w_fifo_dout;

  // Shift registers, bit/word counters and the output strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt   <= '0;
      r_word_cnt  <= '0;
      r_first     <= 1'b0;
      r_rx_shift  <= '0;
      r_tx_shift  <= IDLE_WORD;
      r_work_data <= '0;
      r_work_push <= 1'b0;
      r_work_done <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_work_push <= 1'b0;
      r_work_done <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_start) begin
        r_bit_cnt  <= '0;
        r_word_cnt <= '0;
        r_first    <= 1'b1;
        r_tx_shift <= w_head;
      end else if (w_end) begin
        r_frame_err <= (r_bit_cnt != '0) || (r_word_cnt != WL);
      end else begin
        if (w_rise) begin
          r_rx_shift <= {r_rx_shift[WORD_W-2:0], r_mosi_s2};
          r_bit_cnt  <= r_bit_cnt + 1'b1;
          if (r_bit_cnt == '1) begin
            if (r_word_cnt < WL) begin
              r_work_push <= 1'b1;
              r_work_data <= {r_rx_shift[WORD_W-2:0], r_mosi_s2};
              r_work_done <= (r_word_cnt == WL_M1);
            end
            if (r_word_cnt <= WL) r_word_cnt <= r_word_cnt + 1'b1;
          end
        end
        if (w_fall) begin
          r_first <= 1'b0;
          if ((r_bit_cnt == '0) && !r_first) r_tx_shift <= w_head;
          else                               r_tx_shift <= {r_tx_shift[WORD_W-2:0], 1'b0};
        end
      end
    end
  end

  api_nonce_fifo #(
    .DEPTH (NONCE_DEPTH),
    .WIDTH (WORD_W)
  ) u_nonce_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.nonce_push),
    .pop   (w_pop),
    .din   (bus.nonce_din),
    .dout  (w_fifo_dout),
    .count (w_fifo_count),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  assign bus.busy       = (r_state == ST_ACTIVE);
  assign bus.miso       = (r_state == ST_ACTIVE) & r_tx_shift[WORD_W-1];
  assign bus.work_data  = r_work_data;
  assign bus.work_push  = r_work_push;
  assign bus.work_done  = r_work_done;
  assign bus.frame_err  = r_frame_err;
  assign bus.nonce_full = w_fifo_full;
  assign bus.nonce_cnt  = w_fifo_count;

endmodule

// File: tb/tb_api_miner_spi.sv
// Directed bench for api_miner_spi acting as the API controller and hash core.
module tb_api_miner_spi;
  import api_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  api_miner_spi_if #(.NONCE_DEPTH(8)) bus();

  api_miner_spi #(.NONCE_DEPTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] push_q [$];
  logic [3:0]  cnt_trace [$];
  logic [3:0]  cnt_prev = 4'd0;
  int          done_cnt = 0;
  int          err_cnt  = 0;
  int          done_at  = -1;
  logic [31:0] miso_w [0:31];

  // Passive monitor: records pushed words, strobes and nonce_cnt changes.
  always @(negedge clk) begin
    if (bus.work_push === 1'b1) begin
      push_q.push_back(bus.work_data);
      if (bus.work_done === 1'b1) done_at = push_q.size();
    end
    if (bus.work_done === 1'b1) done_cnt++;
    if (bus.frame_err === 1'b1) err_cnt++;
    if (bus.nonce_cnt !== cnt_prev) begin
      cnt_trace.push_back(bus.nonce_cnt);
      cnt_prev = bus.nonce_cnt;
    end
  end

  task automatic send_bit(input logic b, output logic m);
    bus.mosi = b;
    repeat (4) @(negedge clk);
    bus.sck = 1'b1;
    repeat (4) @(negedge clk);
    m = bus.miso;
    bus.sck = 1'b0;
  endtask

  task automatic run_frame(input int nbits, input logic [31:0] base);
    logic [31:0] w;
    logic        m;
    for (int k = 0; k < 32; k++) miso_w[k] = 32'h0;
    @(negedge clk);
    bus.load = 1'b1;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      w = base + 32'(i / 32);
      send_bit(w[31 - (i % 32)], m);
      miso_w[i / 32][31 - (i % 32)] = m;
    end
    repeat (8) @(negedge clk);
    bus.load = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic push_nonce(input logic [31:0] v);
    @(negedge clk);
    bus.nonce_din  = v;
    bus.nonce_push = 1'b1;
    @(negedge clk);
    bus.nonce_push = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (bus.miso !== 1'b0) begin n_bad++; $display("FAIL reset_miso: got %b want 0", bus.miso); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.nonce_cnt !== 4'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", bus.nonce_cnt); end
    n_cmp++; if (bus.nonce_full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b want 0", bus.nonce_full); end
    n_cmp++; if (bus.work_push !== 1'b0) begin n_bad++; $display("FAIL reset_push: got %b want 0", bus.work_push); end
    n_cmp++; if (bus.frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", bus.frame_err); end
  endtask

  task automatic test_clean_frame();
    int p0, d0, e0;
    p0 = push_q.size(); d0 = done_cnt; e0 = err_cnt;
    run_frame(23 * 32, 32'd1);
    n_cmp++; if (push_q.size() - p0 !== 23) begin n_bad++; $display("FAIL clean_pushes: got %0d want 23", push_q.size() - p0); end
    for (int i = 0; i < 23; i++) begin
      n_cmp++;
      if (push_q[p0 + i] !== 32'(i + 1)) begin n_bad++; $display("FAIL clean_data[%0d]: got %h want %h", i, push_q[p0 + i], 32'(i + 1)); end
    end
    n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL clean_done_cnt: got %0d want 1", done_cnt - d0); end
    n_cmp++; if (done_at !== p0 + 23) begin n_bad++; $display("FAIL clean_done_pos: got %0d want %0d", done_at, p0 + 23); end
    n_cmp++; if (err_cnt - e0 !== 0) begin n_bad++; $display("FAIL clean_err: got %0d want 0", err_cnt - e0); end
    for (int k = 0; k < 23; k++) begin
      n_cmp++;
      if (miso_w[k] !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL clean_miso[%0d]: got %h want ffffffff", k, miso_w[k]); end
    end
  endtask

  task automatic test_nonce_return();
    int t0;
    t0 = cnt_trace.size();
    push_nonce(32'hDEAD_BEEF);
    push_nonce(32'h1234_5678);
    n_cmp++; if (bus.nonce_cnt !== 4'd2) begin n_bad++; $display("FAIL nret_cnt_before: got %0d want 2", bus.nonce_cnt); end
    run_frame(23 * 32, 32'h100);
    n_cmp++; if (miso_w[0] !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL nret_word0: got %h want deadbeef", miso_w[0]); end
    n_cmp++; if (miso_w[1] !== 32'h1234_5678) begin n_bad++; $display("FAIL nret_word1: got %h want 12345678", miso_w[1]); end
    for (int k = 2; k < 23; k++) begin
      n_cmp++;
      if (miso_w[k] !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL nret_idle[%0d]: got %h want ffffffff", k, miso_w[k]); end
    end
    n_cmp++;
    if (cnt_trace.size() - t0 !== 4) begin
      n_bad++; $display("FAIL nret_trace_len: got %0d want 4", cnt_trace.size() - t0);
    end else if (cnt_trace[t0] !== 4'd1 || cnt_trace[t0+1] !== 4'd2 || cnt_trace[t0+2] !== 4'd1 || cnt_trace[t0+3] !== 4'd0) begin
      n_bad++; $display("FAIL nret_trace: got %0d,%0d,%0d,%0d want 1,2,1,0",
                        cnt_trace[t0], cnt_trace[t0+1], cnt_trace[t0+2], cnt_trace[t0+3]);
    end
  endtask

  task automatic test_partial_frame();
    int p0, d0, e0;
    p0 = push_q.size(); d0 = done_cnt; e0 = err_cnt;
    run_frame(5 * 32 + 7, 32'h400);
    n_cmp++; if (push_q.size() - p0 !== 5) begin n_bad++; $display("FAIL part_pushes: got %0d want 5", push_q.size() - p0); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (push_q[p0 + i] !== 32'h400 + 32'(i)) begin n_bad++; $display("FAIL part_data[%0d]: got %h want %h", i, push_q[p0 + i], 32'h400 + 32'(i)); end
    end
    n_cmp++; if (done_cnt - d0 !== 0) begin n_bad++; $display("FAIL part_done: got %0d want 0", done_cnt - d0); end
    n_cmp++; if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL part_err: got %0d want 1", err_cnt - e0); end
  endtask

  task automatic test_fifo_full();
    for (int i = 0; i < 8; i++) push_nonce(32'hC0DE_0000 + 32'(i));
    n_cmp++; if (bus.nonce_full !== 1'b1) begin n_bad++; $display("FAIL full_flag8: got %b want 1", bus.nonce_full); end
    n_cmp++; if (bus.nonce_cnt !== 4'd8) begin n_bad++; $display("FAIL full_cnt8: got %0d want 8", bus.nonce_cnt); end
    push_nonce(32'hC0DE_0008);
    n_cmp++; if (bus.nonce_cnt !== 4'd8) begin n_bad++; $display("FAIL full_cnt9: got %0d want 8", bus.nonce_cnt); end
    n_cmp++; if (bus.nonce_full !== 1'b1) begin n_bad++; $display("FAIL full_flag9: got %b want 1", bus.nonce_full); end
    run_frame(23 * 32, 32'h200);
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (miso_w[k] !== 32'hC0DE_0000 + 32'(k)) begin n_bad++; $display("FAIL full_miso[%0d]: got %h want %h", k, miso_w[k], 32'hC0DE_0000 + 32'(k)); end
    end
    n_cmp++; if (miso_w[8] !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL full_miso8: got %h want ffffffff", miso_w[8]); end
    n_cmp++; if (bus.nonce_cnt !== 4'd0) begin n_bad++; $display("FAIL full_cnt_after: got %0d want 0", bus.nonce_cnt); end
    n_cmp++; if (bus.nonce_full !== 1'b0) begin n_bad++; $display("FAIL full_flag_after: got %b want 0", bus.nonce_full); end
  endtask

  task automatic test_long_frame();
    int p0, d0, e0;
    p0 = push_q.size(); d0 = done_cnt; e0 = err_cnt;
    run_frame(24 * 32, 32'h300);
    n_cmp++; if (push_q.size() - p0 !== 23) begin n_bad++; $display("FAIL long_pushes: got %0d want 23", push_q.size() - p0); end
    for (int i = 0; i < 23; i++) begin
      n_cmp++;
      if (push_q[p0 + i] !== 32'h300 + 32'(i)) begin n_bad++; $display("FAIL long_data[%0d]: got %h want %h", i, push_q[p0 + i], 32'h300 + 32'(i)); end
    end
    n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL long_done: got %0d want 1", done_cnt - d0); end
    n_cmp++; if (done_at !== p0 + 23) begin n_bad++; $display("FAIL long_done_pos: got %0d want %0d", done_at, p0 + 23); end
    n_cmp++; if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL long_err: got %0d want 1", err_cnt - e0); end
  endtask

  task automatic test_reset_mid_frame();
    logic m;
    for (int i = 0; i < 3; i++) push_nonce(32'hA5A5_0000 + 32'(i));
    n_cmp++; if (bus.nonce_cnt !== 4'd3) begin n_bad++; $display("FAIL rmid_cnt_before: got %0d want 3", bus.nonce_cnt); end
    @(negedge clk);
    bus.load = 1'b1;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 10; i++) send_bit(i[0], m);
    bus.sck = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL rmid_busy_before: got %b want 1", bus.busy); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.miso !== 1'b0) begin n_bad++; $display("FAIL rmid_miso: got %b want 0", bus.miso); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.nonce_cnt !== 4'd0) begin n_bad++; $display("FAIL rmid_cnt: got %0d want 0", bus.nonce_cnt); end
    bus.load = 1'b0;
    bus.sck  = 1'b0;
    bus.mosi = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    test_clean_frame();
  endtask

  initial begin
    bus.load       = 1'b0;
    bus.sck        = 1'b0;
    bus.mosi       = 1'b0;
    bus.nonce_din  = 32'h0;
    bus.nonce_push = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    test_clean_frame();
    test_nonce_return();
    test_partial_frame();
    test_fifo_full();
    test_long_frame();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/api_miner_spi.md
Name: api_miner_spi

Overview:
- Miner-side responder for the API serial link.
- Receives work words serially on load/sck/mosi from the API controller and returns nonce words on miso in the same transfer.
- Reassembles incoming 32-bit words and pushes them to the hash core.
- Buffers nonces reported by the hash core in a small FIFO and streams them back MSB first.

Parameters:
- WORK_LEN, 23, words per work frame (736 bits).
- NONCE_DEPTH, 8, nonce FIFO depth (power of 2).
- IDLE_WORD, 32'hFFFFFFFF, word shifted out when the nonce FIFO is empty.

Ports:
- clk  in  1  system clock; must be at least 4x sck.
- rst_n  in  1  reset, asynchronous, active-low.
- load  in  1  frame select from API controller; high = frame active.
- sck  in  1  serial clock from API controller.
- mosi  in  1  serial data from controller.
- miso  out  1  serial data to controller.
- work_data  out  32  reassembled work word.
- work_push  out  1  one-cycle strobe; work_data valid.
- work_done  out  1  one-cycle strobe; WORK_LEN-th word of frame pushed.
- frame_err  out  1  one-cycle strobe at load fall if frame was not exactly WORK_LEN whole words.
- nonce_din  in  32  nonce from hash core.
- nonce_push  in  1  write strobe for nonce_din.
- nonce_full  out  1  nonce FIFO full.
- nonce_cnt  out  log2(NONCE_DEPTH)+1  nonce FIFO occupancy.
- busy  out  1  frame active (synced load high).

Behaviour:
- Reset: all outputs 0, all counters 0, FIFO empty, tx_shift = IDLE_WORD.
- Synchronisation:
  - load, sck and mosi each pass a 2-flop synchroniser, plus one history flop for edge detection.
  - Input-to-internal-event latency is 3 clk.
- Frame start (synced load rise):
  - bit_cnt=0, word_cnt=0, first=1.
  - tx_shift is loaded with the FIFO head (pop) or IDLE_WORD if empty.
  - miso = tx_shift[31] on the next cycle, before the first sck rise.
- sck rise while busy:
  - rx_shift <= {rx_shift[30:0], mosi_s}; bit_cnt increments modulo 32.
  - When bit_cnt wraps 31->0 and word_cnt < WORK_LEN: work_push=1 and work_data=new word, both in the cycle after the edge; word_cnt++.
  - When word_cnt reaches WORK_LEN: work_done=1 in the same cycle as that work_push.
  - Words beyond WORK_LEN are not pushed; they only mark the frame as bad.
- sck fall while busy:
  - If bit_cnt==0 and first==0 (word boundary): reload tx_shift from the FIFO (pop) or IDLE_WORD.
  - Otherwise: tx_shift <<= 1.
  - In both cases miso = new tx_shift[31]; first is cleared.
  - Result: nonce words go out back-to-back, MSB first, 32 bits each.
- Frame end (synced load fall):
  - frame_err=1 for one cycle if bit_cnt!=0 or word_cnt!=WORK_LEN.
  - A partial rx word is discarded; words already pushed stand.
  - A popped nonce whose bits were not fully shifted out is lost; this is accepted and the controller sees a truncated word.
  - busy=0, miso=0.
- sck edges while load is low are ignored; miso is held 0 while idle.
- Nonce FIFO:
  - A push while full is dropped; count unchanged.
  - Push and pop in the same cycle when empty: the pop returns IDLE_WORD and the push is stored; count=1.
  - Push and pop in the same cycle when full: both happen; count unchanged.
  - nonce_full = (nonce_cnt==NONCE_DEPTH).
- Load rise and sck rise detected in the same cycle: frame start takes priority and that sck edge is ignored. This is a controller protocol violation.
- rst_n assertion mid-frame: everything returns to reset values immediately and the FIFO contents are lost.

Decomposition:
- Shared package api_pkg holds WORK_LEN, IDLE_WORD and the word width (32) so that api_ctrl and this block agree on frame geometry.
- One sub-module: api_nonce_fifo.
  - Synchronous FIFO, width 32, depth NONCE_DEPTH.
  - Ports: push, pop, din, dout, count, full, empty.
  - First-word-fall-through dout, so a pop and its data use the same cycle.
- Synchroniser, edge detect, shift registers and counters stay in the top module.

Test Plan:
- Reset with no nonces, one full frame of 23 words 0x00000001..0x00000017 at sck = clk/8:
  - 23 work_push with matching data; work_done with the 23rd push; frame_err never asserts.
  - miso carries 23 x 0xFFFFFFFF.
- Push nonces 0xDEADBEEF and 0x12345678 before the frame, then run a 23-word frame:
  - miso words 0 and 1 = 0xDEADBEEF, 0x12345678; words 2-22 = 0xFFFFFFFF; nonce_cnt goes 2->1->0.
- Drop load after 5 words + 7 bits:
  - 5 work_push; frame_err pulses once; no work_done; no sixth push.
- Push 9 nonces into NONCE_DEPTH=8:
  - nonce_full=1 after the 8th; the 9th is dropped; nonce_cnt=8.
  - The next frame returns the first 8 in order.
- Frame of 24 words:
  - 23 work_push, work_done on the 23rd; the 24th is not pushed; frame_err at load fall.
- Assert rst_n low mid-word during a frame with 3 nonces queued:
  - miso=0, busy=0, nonce_cnt=0 immediately.
  - A following clean frame behaves as the first scenario.
